// File: rtl/clock_pkg.sv
// Shared definitions for the settable timekeeping core: set-mode state encoding,
// field limits and small display helpers.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2
    } set_state_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Hour as shown on the display; the internal hour is always 0-23.
    function automatic logic [4:0] display_hour(input logic [4:0] h, input logic fmt12);
        if (!fmt12) begin
            return h;
        end else if (h == 5'd0) begin
            return 5'd12;
        end else if (h > 5'd12) begin
            return h - 5'd12;
        end else begin
            return h;
        end
    endfunction

    // Split a 0-99 value into {tens, ones} BCD digits.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) counter with a carry-chain enable and a carry-free set increment.
// wrap flags the carry out of a counting step; increments from set mode never carry.
module mod_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         rst,
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic at_max;

    assign at_max = (value == MAX_V);
    assign wrap   = en & at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en || inc) begin
            value <= at_max ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/clock_core_settable.sv
// Single-clock timekeeping core: tick prescaler, RUN/SET_H/SET_M set-mode FSM,
// seconds/minutes/hours chain and BCD display digits with optional 12-hour format.
module clock_core_settable
    import clock_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int QUICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       quick,
    input  logic       run_en,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       fmt12,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [3:0] h10,
    output logic [3:0] h1,
    output logic [3:0] m10,
    output logic [3:0] m1,
    output logic [3:0] s10,
    output logic [3:0] s1,
    output logic       pm,
    output logic [1:0] set_state,
    output logic       blink
);

    localparam int TERM_Q = CLK_HZ / QUICK_DIV;
    localparam int CNT_W  = $clog2(CLK_HZ);

    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] LAST_Q = CNT_W'(TERM_Q - 1);
    localparam logic [CNT_W-1:0] HALF_N = CNT_W'(CLK_HZ / 2);
    localparam logic [CNT_W-1:0] HALF_Q = CNT_W'(TERM_Q / 2);

    set_state_t       state, state_nx;
    logic             mode_cur, mode_prev, inc_cur, inc_prev, quick_q;
    logic             mode_edge, inc_edge, quick_chg;
    logic [CNT_W-1:0] pre_cnt, pre_last, pre_half;
    logic             pre_en, tick;
    logic             pre_clr, sec_clr, count_en, hour_inc, min_inc;
    logic             sec_wrap, min_wrap, hour_wrap_unused;
    logic [4:0]       dh;

    // Buttons are sampled once; an action fires on the registered rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_cur  <= 1'b0;
            mode_prev <= 1'b0;
            inc_cur   <= 1'b0;
            inc_prev  <= 1'b0;
            quick_q   <= 1'b0;
        end else begin
            mode_cur  <= mode_btn;
            mode_prev <= mode_cur;
            inc_cur   <= inc_btn;
            inc_prev  <= inc_cur;
            quick_q   <= quick;
        end
    end

    assign mode_edge = mode_cur & ~mode_prev;
    assign inc_edge  = inc_cur & ~inc_prev;
    assign quick_chg = quick ^ quick_q;

    // The prescaler keeps running in set mode so blink keeps pulsing while paused.
    assign pre_en   = (state != ST_RUN) | run_en;
    assign pre_last = quick ? LAST_Q : LAST_N;
    assign pre_half = quick ? HALF_Q : HALF_N;
    assign tick     = pre_en & ~quick_chg & (pre_cnt == pre_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_clr || quick_chg) begin
            pre_cnt <= '0;
        end else if (pre_en) begin
            pre_cnt <= tick ? '0 : pre_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:   if (mode_edge) state_nx = ST_SET_H;
            ST_SET_H: if (mode_edge) state_nx = ST_SET_M;
            ST_SET_M: if (mode_edge) state_nx = ST_RUN;
            default:  state_nx = ST_RUN;
        endcase
    end

    // A mode edge always wins over an inc edge arriving in the same cycle.
    always_comb begin
        pre_clr  = 1'b0;
        sec_clr  = 1'b0;
        count_en = 1'b0;
        hour_inc = 1'b0;
        min_inc  = 1'b0;
        blink    = 1'b0;
        case (state)
            ST_RUN: begin
                sec_clr  = mode_edge;
                pre_clr  = mode_edge;
                count_en = tick & ~mode_edge;
            end
            ST_SET_H: begin
                hour_inc = inc_edge & ~mode_edge;
                blink    = (pre_cnt < pre_half);
            end
            ST_SET_M: begin
                min_inc  = inc_edge & ~mode_edge;
                pre_clr  = mode_edge;
                blink    = (pre_cnt < pre_half);
            end
            default: begin
                pre_clr  = 1'b0;
            end
        endcase
    end

    assign set_state = state;

    mod_counter #(.MAX(SEC_MAX), .W(6)) u_sec (
        .rst   (rst),
        .clk   (clk),
        .clr   (sec_clr),
        .en    (count_en),
        .inc   (1'b0),
        .value (second),
        .wrap  (sec_wrap)
    );

    mod_counter #(.MAX(MIN_MAX), .W(6)) u_min (
        .rst   (rst),
        .clk   (clk),
        .clr   (1'b0),
        .en    (sec_wrap),
        .inc   (min_inc),
        .value (minute),
        .wrap  (min_wrap)
    );

    mod_counter #(.MAX(HOUR_MAX), .W(5)) u_hour (
        .rst   (rst),
        .clk   (clk),
        .clr   (1'b0),
        .en    (min_wrap),
        .inc   (hour_inc),
        .value (hour),
        .wrap  (hour_wrap_unused)
    );

    assign pm = (hour >= 5'd12);
    assign dh = display_hour(hour, fmt12);

    assign {h10, h1} = to_bcd({2'b00, dh});
    assign {m10, m1} = to_bcd({1'b0, minute});
    assign {s10, s1} = to_bcd({1'b0, second});

endmodule

// File: tb/tb_clock_core_settable.sv
// Bench for clock_core_settable: a time-of-day reference model feeds an expected
// queue of output snapshots that a monitor pops whenever the DUT outputs change.
module tb_clock_core_settable;

    localparam int CLK_HZ    = 10;
    localparam int QUICK_DIV = 5;
    localparam int SW        = 45;

    logic       clk = 1'b0;
    logic       rst, quick, run_en, mode_btn, inc_btn, fmt12;
    logic [4:0] hour;
    logic [5:0] minute, second;
    logic [3:0] h10, h1, m10, m1, s10, s1;
    logic       pm, blink;
    logic [1:0] set_state;

    clock_core_settable #(.CLK_HZ(CLK_HZ), .QUICK_DIV(QUICK_DIV)) dut (
        .clk(clk), .rst(rst), .quick(quick), .run_en(run_en), .mode_btn(mode_btn),
        .inc_btn(inc_btn), .fmt12(fmt12), .hour(hour), .minute(minute), .second(second),
        .h10(h10), .h1(h1), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
        .pm(pm), .set_state(set_state), .blink(blink)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time of day in seconds, tick phase, set-mode step.
    int m_tod = 0, m_pc = 0, m_st = 0;
    bit m_mcur = 0, m_mprev = 0, m_icur = 0, m_iprev = 0, m_qprev = 0;

    function automatic int term_of(input bit q);
        return q ? CLK_HZ / QUICK_DIV : CLK_HZ;
    endfunction

    always @(posedge clk or posedge rst) begin : model_step
        bit mode_e, inc_e, q_chg, adv, tk;
        int hh, mm;
        if (rst) begin
            m_tod = 0; m_pc = 0; m_st = 0;
            m_mcur = 0; m_mprev = 0; m_icur = 0; m_iprev = 0; m_qprev = 0;
        end else begin
            mode_e = m_mcur && !m_mprev;
            inc_e  = m_icur && !m_iprev;
            q_chg  = (quick != m_qprev);
            adv    = (m_st != 0) || run_en;
            tk     = adv && !q_chg && (m_pc == term_of(quick) - 1);
            hh     = m_tod / 3600;
            mm     = (m_tod / 60) % 60;
            if (mode_e) begin
                if (m_st == 0) m_tod = m_tod - (m_tod % 60);
            end else if (inc_e && m_st == 1) begin
                m_tod = m_tod + (((hh + 1) % 24) - hh) * 3600;
            end else if (inc_e && m_st == 2) begin
                m_tod = m_tod + (((mm + 1) % 60) - mm) * 60;
            end else if (m_st == 0 && tk) begin
                m_tod = (m_tod + 1) % 86400;
            end
            if (q_chg || (mode_e && m_st != 1)) m_pc = 0;
            else if (adv) m_pc = (m_pc + 1) % term_of(quick);
            if (mode_e) m_st = (m_st + 1) % 3;
            m_mprev = m_mcur; m_mcur = mode_btn;
            m_iprev = m_icur; m_icur = inc_btn;
            m_qprev = quick;
        end
    end

    function automatic logic [SW-1:0] model_snap();
        int hh, mm, ss, dh;
        bit blk;
        hh  = m_tod / 3600;
        mm  = (m_tod / 60) % 60;
        ss  = m_tod % 60;
        dh  = fmt12 ? ((hh == 0) ? 12 : ((hh > 12) ? hh - 12 : hh)) : hh;
        blk = (m_st != 0) && (m_pc < term_of(quick) / 2);
        return {5'(hh), 6'(mm), 6'(ss), 1'(hh >= 12), 2'(m_st), 1'(blk),
                4'(dh / 10), 4'(dh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    logic [SW-1:0] dut_snap;
    assign dut_snap = {hour, minute, second, pm, set_state, blink, h10, h1, m10, m1, s10, s1};

    // Scoreboard: model snapshots queued on change, stamped with their cycle.
    logic [SW-1:0] exp_q[$];
    int            stamp_q[$];
    int            cyc = 0;
    bit            started = 0, exp_init = 0, dut_init = 0;
    logic [SW-1:0] last_exp, last_dut;

    always @(negedge clk) begin : sampler
        logic [SW-1:0] snap;
        if (started) begin
            snap = model_snap();
            if (!exp_init) begin
                last_exp = snap;
                exp_init = 1;
            end else if (snap != last_exp) begin
                exp_q.push_back(snap);
                stamp_q.push_back(cyc);
                last_exp = snap;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [SW-1:0] cur, e;
        int            s;
        #1;
        if (started && exp_init) begin
            cur = dut_snap;
            if (!dut_init) begin
                checks++;
                if (cur !== last_exp) begin
                    errors++;
                    $display("FAIL baseline actual=%h expected=%h", cur, last_exp);
                end
                last_dut = cur;
                dut_init = 1;
            end else begin
                while (stamp_q.size() > 0 && stamp_q[0] < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_change cyc=%0d expected=%h stamp=%0d", cyc, exp_q[0], stamp_q[0]);
                    void'(exp_q.pop_front());
                    void'(stamp_q.pop_front());
                end
                if (cur !== last_dut) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change cyc=%0d actual=%h expected=%h", cyc, cur, last_dut);
                    end else begin
                        e = exp_q.pop_front();
                        s = stamp_q.pop_front();
                        if (cur !== e || s != cyc) begin
                            errors++;
                            $display("FAIL snapshot cyc=%0d actual=%h expected=%h expected_cyc=%0d", cyc, cur, e, s);
                        end
                    end
                    last_dut = cur;
                end
            end
        end
        cyc++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance n clocks and return at the drive point just after the edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input bit is_mode, input int hold);
        if (is_mode) mode_btn = 1'b1;
        else inc_btn = 1'b1;
        cycles(hold);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        cycles(3);
    endtask

    task automatic press_n(input bit is_mode, input int n);
        for (int i = 0; i < n; i++) press(is_mode, 2);
    endtask

    task automatic wait_sec(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (second != 6'(target) && n < budget) begin
            cycles(1);
            n++;
        end
        chk(name, int'(second), target);
    endtask

    task automatic wait_change(input string name, input int exp_n);
        int s0, n;
        s0 = m_tod % 60;
        n  = 0;
        while (int'(second) == s0 && n < 30) begin
            cycles(1);
            n++;
        end
        chk(name, n, exp_n);
    endtask

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int s_hold, m_keep, hi, lo, n;
        rst = 1'b1; quick = 1'b0; run_en = 1'b1;
        mode_btn = 1'b0; inc_btn = 1'b0; fmt12 = 1'b0;
        cycles(3);

        // Reset values, including the 12-hour reset display.
        chk("rst_hour", int'(hour), 0);
        chk("rst_second", int'(second), 0);
        chk("rst_state", int'(set_state), 0);
        chk("rst_blink", int'(blink), 0);
        chk("rst_pm", int'(pm), 0);
        fmt12 = 1'b1;
        #1;
        chk("rst_12h_digits", int'({h10, h1}), 8'h12);
        fmt12 = 1'b0;
        rst = 1'b0;
        started = 1;

        cycles(9);
        chk("before_first_tick", int'(second), 0);
        cycles(1);
        chk("first_tick", int'(second), 1);

        // Asynchronous reset mid-count.
        wait_sec("reach_7s", 7, 100);
        cycles(4);
        rst = 1'b1;
        #1;
        chk("async_rst_second", int'(second), 0);
        chk("async_rst_blink", int'(blink), 0);
        chk("async_rst_s1", int'(s1), 0);
        cycles(2);
        rst = 1'b0;

        // Preset 23:59 and roll over midnight.
        press(1, 2);
        chk("set_h_entry_state", int'(set_state), 1);
        chk("set_h_entry_second", int'(second), 0);
        press_n(0, 23);
        press(1, 2);
        press_n(0, 59);
        press(1, 2);
        chk("preset_state", int'(set_state), 0);
        chk("preset_hm", int'({hour, minute}), int'({5'd23, 6'd59}));
        wait_sec("reach_59s", 59, 700);
        chk("pre_roll_pm", int'(pm), 1);
        n = 0;
        while (second == 6'd59 && n < 12) begin
            cycles(1);
            n++;
        end
        chk("rollover_time", int'({hour, minute, second}), 0);
        chk("rollover_pm", int'(pm), 0);

        // Quick rate, quick toggling, pause.
        quick = 1'b1;
        wait_change("quick_first", 1 + CLK_HZ / QUICK_DIV);
        wait_change("quick_period", CLK_HZ / QUICK_DIV);
        quick = 1'b0;
        cycles(1);
        quick = 1'b1;
        wait_change("quick_toggle", 1 + CLK_HZ / QUICK_DIV);
        run_en = 1'b0;
        s_hold = m_tod % 60;
        cycles(50);
        chk("pause_hold", int'(second), s_hold);
        run_en = 1'b1;
        quick = 1'b0;
        cycles(5);

        // Set mode walk-through.
        press(1, 2);
        chk("set_h_state", int'(set_state), 1);
        chk("set_h_second", int'(second), 0);
        press_n(0, 13);
        chk("set_hour_13", int'(hour), 13);
        chk("set_hour_13_pm", int'(pm), 1);
        fmt12 = 1'b1;
        #1;
        chk("fmt12_13", int'({h10, h1}), 8'h01);
        fmt12 = 1'b0;
        press(1, 2);
        chk("set_m_state", int'(set_state), 2);
        m_keep = int'(minute);
        press_n(0, 61);
        chk("set_minute_61", int'(minute), (m_keep + 1) % 60);
        chk("set_minute_hour", int'(hour), 13);
        press(1, 2);
        chk("back_to_run", int'(set_state), 0);

        // Held inc and simultaneous mode/inc.
        press(1, 2);
        press(0, 20);
        chk("held_inc", int'(hour), 14);
        m_keep = int'(minute);
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        cycles(2);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        cycles(3);
        chk("simul_state", int'(set_state), 2);
        chk("simul_hour", int'(hour), 14);
        chk("simul_minute", int'(minute), m_keep);
        press(1, 2);
        press(1, 2);

        // 12-hour display at midnight and noon; blink pattern in SET_H.
        fmt12 = 1'b1;
        press_n(0, 10);
        chk("h0_display", int'({h10, h1}), 8'h12);
        chk("h0_pm", int'(pm), 0);
        press_n(0, 12);
        chk("h12_display", int'({h10, h1}), 8'h12);
        chk("h12_pm", int'(pm), 1);
        n = 0;
        while (blink == 1'b1 && n < 30) begin cycles(1); n++; end
        n = 0;
        while (blink == 1'b0 && n < 30) begin cycles(1); n++; end
        hi = 0;
        while (blink == 1'b1 && hi < 30) begin cycles(1); hi++; end
        lo = 0;
        while (blink == 1'b0 && lo < 30) begin cycles(1); lo++; end
        chk("blink_high", hi, CLK_HZ / 2);
        chk("blink_low", lo, CLK_HZ - CLK_HZ / 2);
        press(1, 2);
        press(1, 2);
        cycles(3);
        chk("blink_run", int'(blink), 0);
        fmt12 = 1'b0;

        // Randomised mix of all inputs, checked by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, 2) == 0) inc_btn = ~inc_btn;
            if ($urandom_range(0, 39) == 0) run_en = ~run_en;
            if ($urandom_range(0, 59) == 0) quick = ~quick;
            if ($urandom_range(0, 29) == 0) fmt12 = ~fmt12;
            rst = (i == 1500);
            cycles(1);
        end
        rst = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        cycles(5);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
